// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbitration logic.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      HOLD
   } disp_state_t;

   localparam int DISP_DATA_W = 32;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_priority_select #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic                       valid,
   output logic [$clog2(NUM_REQ)-1:0] winner
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = IDX_W + 1;

   // Bit k of rotated is the request of requester (ptr + k) mod NUM_REQ.
   logic [NUM_REQ-1:0]            rotated;
   logic [NUM_REQ:0]              found;
   logic [NUM_REQ:0][IDX_W-1:0]   win_acc;

   assign rotated    = NUM_REQ'({req, req} >> ptr);
   assign found[0]   = 1'b0;
   assign win_acc[0] = '0;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_off
         logic [SUM_W-1:0] sum;
         logic [IDX_W-1:0] wrapped;
         logic             first;

         assign sum          = {1'b0, ptr} + SUM_W'(gi);
         assign wrapped      = IDX_W'((sum >= SUM_W'(NUM_REQ)) ? sum - SUM_W'(NUM_REQ) : sum);
         assign first        = rotated[gi] & ~found[gi];
         assign found[gi+1]  = found[gi] | rotated[gi];
         assign win_acc[gi+1] = win_acc[gi] | (first ? wrapped : '0);
      end
   endgenerate

   assign valid  = found[NUM_REQ];
   assign winner = win_acc[NUM_REQ];

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of one seven-segment display between several requesters,
// with a minimum hold time per granted value.
module display_arbiter
   import display_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 100000000,
   parameter int DATA_W      = DISP_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [DATA_W-1:0]           number,
   output logic                        load,
   output logic [NUM_REQ-1:0]          ack,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   disp_state_t                         state_q, state_d;
   logic [IDX_W-1:0]                    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [DATA_W-1:0]                   number_q, number_d;
   logic [IDX_W-1:0]                    grant_id_q, grant_id_d;
   logic                                load_q, load_d;
   logic [NUM_REQ-1:0]                  ack_q, ack_d;

   logic                                sel_valid;
   logic [IDX_W-1:0]                    sel_winner;
   logic [NUM_REQ-1:0][DATA_W-1:0]      req_arr;

   assign req_arr = req_data;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ)
   ) u_select (
      .req    (req),
      .ptr    (rr_ptr_q),
      .valid  (sel_valid),
      .winner (sel_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         number_q   <= '0;
         grant_id_q <= '0;
         load_q     <= 1'b0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         number_q   <= number_d;
         grant_id_q <= grant_id_d;
         load_q     <= load_d;
         ack_q      <= ack_d;
      end
   end

   // load/ack are set on the grant edge so they are high exactly while in LOAD.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      number_d   = number_q;
      grant_id_d = grant_id_q;
      load_d     = 1'b0;
      ack_d      = '0;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               number_d   = req_arr[sel_winner];
               grant_id_d = sel_winner;
               rr_ptr_d   = (sel_winner == IDX_W'(NUM_REQ - 1)) ? '0 : sel_winner + 1'b1;
               load_d     = 1'b1;
               ack_d      = NUM_REQ'(1) << sel_winner;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign number   = number_q;
   assign load     = load_q;
   assign ack      = ack_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit seven-segment display between NUM_REQ requesters, e.g. ALU result, operand A, operand B and status word.
- Round-robin arbitration with a minimum on-screen hold time, so each granted value stays readable before another requester can take the display.
- Drives the display driver's `number`/`load` inputs directly and returns a one-cycle `ack` to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 100000000, minimum clk cycles a granted value is held before re-arbitration (1 s at 100 MHz); must be >= 1.
- DATA_W, 32, width of each requester's value.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held high until that requester's ack.
- req_data  input  NUM_REQ*DATA_W  packed values; requester i occupies bits [i*DATA_W +: DATA_W].
- number  output  DATA_W  registered value presented to the display driver.
- load  output  1  one-cycle pulse telling the display driver to capture `number`.
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester, coincident with `load`.
- grant_id  output  $clog2(NUM_REQ)  index of the requester currently on screen.
- busy  output  1  high while in LOAD or HOLD.

Behaviour:
- Reset values: number=0, load=0, ack=0, grant_id=0, busy=0, state=IDLE, rr_ptr=0, hold counter=0.
- Reset is asynchronous: asserting rst mid-HOLD or mid-LOAD aborts immediately; no ack is issued for the aborted grant.
- States: IDLE, LOAD, HOLD.
- IDLE: if any req bit is high at a rising edge, select winner w = first set bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0. Then on that same edge:
  - number <= req_data[w];
  - grant_id <= w;
  - rr_ptr <= (w+1) mod NUM_REQ;
  - state <= LOAD.
- IDLE with no req: stay in IDLE; outputs hold their last values.
- LOAD (exactly 1 cycle): load=1, ack[w]=1, busy=1. Next state is HOLD with counter=0.
- HOLD: busy=1; counter increments each cycle. When counter==HOLD_CYCLES-1, next state is IDLE.
  - Requests are ignored while in HOLD.
  - number and grant_id stay stable throughout HOLD.
- Latency: req sampled in IDLE -> load/ack visible 1 cycle later.
- Minimum spacing between consecutive load pulses: HOLD_CYCLES+2 cycles.
- load and ack are registered outputs, asserted only in LOAD; both are 0 in every other state.
- req_data is sampled only at the grant edge; changes afterwards do not affect number.
- A requester that drops req before being granted is simply skipped; nothing is latched for it.
- Fairness: a requester that holds req continuously is granted within NUM_REQ arbitration rounds.
- A requester may re-request immediately after its ack; it competes in the next IDLE like any other requester.
- rr_ptr wraps mod NUM_REQ. When NUM_REQ is not a power of two, pointer values >= NUM_REQ must never occur.
- Hold counter width is $clog2(HOLD_CYCLES+1). It wraps to 0 on every entry to HOLD.

Decomposition:
- Shared package `display_pkg`:
  - state enum `disp_state_t` {IDLE, LOAD, HOLD};
  - localparam DISP_DATA_W = 32.
- One sub-module: `rr_priority_select`. Purely combinational; inputs req vector and rr_ptr; outputs valid and winner index. Reusable by other arbiters in the design.

Test Plan:
- Bench uses HOLD_CYCLES=4, NUM_REQ=4 unless noted.
- Single request: req=4'b0010, req_data[1]=32'hDEADBEEF -> 1 cycle later load=1, ack=4'b0010, number=32'hDEADBEEF, grant_id=1; busy high for 5 cycles; then IDLE.
- Round robin: req=4'b1111 held continuously, req_data[i]=i+1 -> load pulses every 6 cycles with number 1,2,3,4,1; grant_id 0,1,2,3,0.
- Wrap from pointer: req=4'b0001 granted first (rr_ptr=1); then req=4'b1001 -> requester 3 wins before 0.
- Data change during hold: grant requester 2 with 32'h0000_1234, then change req_data[2] to 32'hFFFF_FFFF during HOLD -> number stays 32'h0000_1234 until the next grant.
- Withdrawn request: req[1] pulsed high for one cycle while in HOLD -> no ack[1], no load.
- Reset mid-hold: assert rst 2 cycles into HOLD -> all outputs 0 asynchronously (before the next clk edge); after release with req=4'b0100 -> grant_id=2, ack=4'b0100 one cycle after the first sampling edge.
